// File: rtl/step_sequencer_pkg.sv
// Shared types and helpers for the step sequencer.
// Optional one-hot output is enabled with STEP_SEQUENCER_ONEHOT_EN (see step_sequencer.sv).
package step_sequencer_pkg;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  localparam logic DIR_FWD  = 1'b1;
  localparam logic DIR_BACK = 1'b0;

  localparam logic [1:0] REQ_HOLD = 2'd0;
  localparam logic [1:0] REQ_FWD  = 2'd1;
  localparam logic [1:0] REQ_BACK = 2'd2;

endpackage

// File: rtl/step_sequencer_prescaler.sv
// Move-opportunity prescaler: otick is high on the last cycle of every PRESCALE-cycle window.
module step_sequencer_prescaler
  import step_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic iclr_cnt,
  output logic otick
);

  localparam int unsigned CW = clog2(PRESCALE);
  localparam logic [CW-1:0] CntLast = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign otick = (cnt_q == CntLast);

  // Count up, return to 0 after the tick or when the index is cleared/loaded.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (iclr_cnt || otick) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_sequencer.sv
// Parametrised step sequencer: walks an index through 0..NSTATES-1 under stop/back control,
// with prescaler, synchronous clear/load, wrap or saturate, and boundary pulses.
// Define STEP_SEQUENCER_ONEHOT_EN to add the registered one-hot output oonehot.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned NSTATES  = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned WRAP     = 1,
  localparam int unsigned W       = clog2(NSTATES)
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         istop,
  input  logic         iback,
  input  logic         iclr,
  input  logic         iload,
  input  logic [W-1:0] iload_val,
  output logic [W-1:0] ovalor,
  output logic         odir,
  output logic         owrap,
  output logic         olimit
`ifdef STEP_SEQUENCER_ONEHOT_EN
  ,
  output logic [NSTATES-1:0] oonehot
`endif
);

  localparam logic [W-1:0] Last = W'(NSTATES - 1);

  logic         tick;
  logic [1:0]   req;
  logic [W-1:0] val_q, val_d, load_val;
  logic         dir_q, dir_d;
  logic         wrap_q, wrap_d;
  logic         limit_q, limit_d;
  logic         val_illegal;

  step_sequencer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .iclr_cnt(iclr | iload),
    .otick   (tick)
  );

  // Codes >= NSTATES only exist when NSTATES is not a power of two.
  if (NSTATES == (1 << W)) begin : g_pow2
    assign val_illegal = 1'b0;
    assign load_val    = iload_val;
  end else begin : g_npow2
    assign val_illegal = (val_q > Last);
    assign load_val    = (iload_val > Last) ? Last : iload_val;
  end

  // Decode the panel controls into a move request; forward wins over back.
  always_comb begin
    req = REQ_HOLD;
    if (tick) begin
      if (!istop)     req = REQ_FWD;
      else if (iback) req = REQ_BACK;
    end
  end

  // Next index, direction and boundary pulses.
  always_comb begin
    val_d   = val_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    limit_d = 1'b0;
    if (iclr) begin
      val_d = '0;
    end else if (iload) begin
      val_d = load_val;
    end else if (val_illegal) begin
      val_d = '0;  // upset recovery, independent of the prescaler
    end else begin
      case (req)
        REQ_FWD: begin
          if (val_q != Last) begin
            val_d = val_q + W'(1);
            dir_d = DIR_FWD;
          end else if (WRAP != 0) begin
            val_d  = '0;
            dir_d  = DIR_FWD;
            wrap_d = 1'b1;
          end else begin
            limit_d = 1'b1;
          end
        end
        REQ_BACK: begin
          if (val_q != '0) begin
            val_d = val_q - W'(1);
            dir_d = DIR_BACK;
          end else if (WRAP != 0) begin
            val_d  = Last;
            dir_d  = DIR_BACK;
            wrap_d = 1'b1;
          end else begin
            limit_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and pulse registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      val_q   <= '0;
      dir_q   <= DIR_FWD;
      wrap_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      limit_q <= limit_d;
    end
  end

  assign ovalor = val_q;
  assign odir   = dir_q;
  assign owrap  = wrap_q;
  assign olimit = limit_q;

`ifdef STEP_SEQUENCER_ONEHOT_EN
  logic [NSTATES-1:0] onehot_q;

  // One-hot copy of the index, updated alongside it.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) onehot_q <= NSTATES'(1);
    else         onehot_q <= NSTATES'(1) << val_d;
  end

  assign oonehot = onehot_q;
`endif

endmodule
